// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the
// write-back path and the MDU; pipeline wins, MDU result is buffered.
// Ports: i_clk, i_rst_n (sync, active-low); i_pipe_* write-back request;
//   i_mdu_* / o_mdu_ready MDU result handshake; o_pipe_stall forced drain;
//   o_rf_* registered write port; o_busy / o_buf_rd buffer status.
module wb_port_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_pipe_valid,
    input  logic              i_pipe_we,
    input  logic [ADDR_W-1:0] i_pipe_rd,
    input  logic [DATA_W-1:0] i_pipe_data,
    input  logic              i_mdu_valid,
    input  logic [ADDR_W-1:0] i_mdu_rd,
    input  logic [DATA_W-1:0] i_mdu_data,
    output logic              o_mdu_ready,
    output logic              o_pipe_stall,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_buf_rd
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HOLD  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_MAX);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic [ADDR_W-1:0] r_buf_rd;
    logic [ADDR_W-1:0] w_buf_rd_nxt;
    logic [DATA_W-1:0] r_buf_data;
    logic [DATA_W-1:0] w_buf_data_nxt;

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;

    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    logic              w_ready;
    logic              w_stall;
    logic              w_pw;
    logic              w_acc_nz;
    logic              w_same_rd;

    assign w_ready   = (r_state == S_EMPTY);
    assign w_stall   = (r_state == S_FORCE);
    assign w_pw      = i_pipe_valid & i_pipe_we
                     & (i_pipe_rd != '0) & ~w_stall;
    // rd 0 results are accepted by the handshake but never written
    assign w_acc_nz  = i_mdu_valid & w_ready & (i_mdu_rd != '0);
    assign w_same_rd = (i_pipe_rd == r_buf_rd);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_buf_rd_nxt   = r_buf_rd;
        w_buf_data_nxt = r_buf_data;
        w_we           = 1'b0;
        w_waddr        = r_rf_waddr;
        w_wdata        = r_rf_wdata;
        case (r_state)
            S_EMPTY: begin
                if (w_pw) begin
                    w_we    = 1'b1;
                    w_waddr = i_pipe_rd;
                    w_wdata = i_pipe_data;
                    if (w_acc_nz) begin
                        w_buf_rd_nxt   = i_mdu_rd;
                        w_buf_data_nxt = i_mdu_data;
                        w_cnt_nxt      = '0;
                        w_state_nxt    = S_HOLD;
                    end
                end else if (w_acc_nz) begin
                    w_we    = 1'b1;
                    w_waddr = i_mdu_rd;
                    w_wdata = i_mdu_data;
                end
            end
            S_HOLD: begin
                if (w_pw) begin
                    w_we    = 1'b1;
                    w_waddr = i_pipe_rd;
                    w_wdata = i_pipe_data;
                    if (w_same_rd) begin
                        // younger pipeline write supersedes the held result
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_EMPTY;
                    end else begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == CNT_LIMIT) begin
                            w_state_nxt = S_FORCE;
                        end
                    end
                end else begin
                    w_we        = 1'b1;
                    w_waddr     = r_buf_rd;
                    w_wdata     = r_buf_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FORCE: begin
                w_we        = 1'b1;
                w_waddr     = r_buf_rd;
                w_wdata     = r_buf_data;
                w_cnt_nxt   = '0;
                w_state_nxt = S_EMPTY;
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= S_EMPTY;
            r_cnt      <= '0;
            r_buf_rd   <= '0;
            r_buf_data <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_buf_rd   <= w_buf_rd_nxt;
            r_buf_data <= w_buf_data_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_rf_we    <= w_we;
            r_rf_waddr <= w_waddr;
            r_rf_wdata <= w_wdata;
        end
    end

    assign o_mdu_ready  = w_ready;
    assign o_pipe_stall = w_stall;
    assign o_rf_we      = r_rf_we;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_rf_wdata   = r_rf_wdata;
    assign o_busy       = ~w_ready;
    assign o_buf_rd     = w_ready ? '0 : r_buf_rd;

endmodule
